// File: rtl/rv32i_irq_controller.sv
// -----------------------------------------------------------------------------
// rv32i_irq_controller
// Machine-level external interrupt source for the RV32I core.
// Captures rising edges on the peripheral interrupt lines as pending bits,
// masks them with a per-source enable, picks the lowest-index candidate and
// presents a single registered request with its cause code to the core. A new
// request is only raised after the core has acknowledged the trap and then
// signalled handler completion (MRET).
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   irq_src       interrupt lines (rising edge = event)
//   irq_enable    per-source enable, masks arbitration only
//   irq_ack       pulse: trap taken for the presented request
//   irq_complete  pulse: handler finished (MRET)
//   irq_req       registered request to the core (mei_exception)
//   irq_cause     registered cause code (mei_cause)
//   active_id     index of the source being requested or serviced
//   pending       registered pending bits
// -----------------------------------------------------------------------------
module rv32i_irq_controller #(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_000B
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_enable,
    input  logic               irq_ack,
    input  logic               irq_complete,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    output logic [4:0]         active_id,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_r;
    logic [NUM_SRC-1:0] prev_src_r;
    logic [NUM_SRC-1:0] pending_r;
    logic               irq_req_r;
    logic [31:0]        irq_cause_r;
    logic [4:0]         active_id_r;

    logic [NUM_SRC-1:0] event_s;
    logic [NUM_SRC-1:0] cand_mask_s;
    logic [NUM_SRC-1:0] clr_mask_s;
    logic [NUM_SRC-1:0] pending_next_s;
    logic               any_cand_s;
    logic               ack_take_s;
    logic [4:0]         cand_id_s;

    // Edge detect, candidate mask and acknowledge qualification
    always_comb begin
        event_s     = irq_src & ~prev_src_r;
        cand_mask_s = pending_r & irq_enable;
        any_cand_s  = |cand_mask_s;
        // An ack only counts while a request is actually being presented
        ack_take_s  = (state_r == ST_REQ) && irq_ack;
    end

    // Fixed-priority encoder: scan downwards so the lowest index wins
    always_comb begin
        cand_id_s = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            cand_id_s = cand_mask_s[i] ? 5'(i) : cand_id_s;
        end
    end

    // Pending update: clear the acknowledged source, but a fresh edge wins
    always_comb begin
        clr_mask_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_mask_s[i] = ack_take_s && (active_id_r == 5'(i));
        end
        pending_next_s = (pending_r & ~clr_mask_s) | event_s;
    end

    // Edge-capture history and pending register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_src_r <= '0;
            pending_r  <= '0;
        end else begin
            prev_src_r <= irq_src;
            pending_r  <= pending_next_s;
        end
    end

    // Request/service FSM with registered request, cause and active index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            irq_req_r   <= 1'b0;
            irq_cause_r <= 32'd0;
            active_id_r <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_cand_s) begin
                        state_r     <= ST_REQ;
                        active_id_r <= cand_id_s;
                        irq_req_r   <= 1'b1;
                        irq_cause_r <= CAUSE_BASE + {27'd0, cand_id_s};
                    end else begin
                        irq_req_r   <= 1'b0;
                        irq_cause_r <= 32'd0;
                        active_id_r <= 5'd0;
                    end
                end
                ST_REQ: begin
                    // Request is held stable; no withdrawal or re-arbitration
                    if (ack_take_s) begin
                        state_r     <= ST_SERVICE;
                        irq_req_r   <= 1'b0;
                        irq_cause_r <= 32'd0;
                    end else begin
                        irq_req_r   <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (irq_complete) begin
                        state_r     <= ST_IDLE;
                        active_id_r <= 5'd0;
                    end else begin
                        irq_req_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    irq_req_r   <= 1'b0;
                    irq_cause_r <= 32'd0;
                    active_id_r <= 5'd0;
                end
            endcase
        end
    end

    assign irq_req   = irq_req_r;
    assign irq_cause = irq_cause_r;
    assign active_id = active_id_r;
    assign pending   = pending_r;

endmodule

// File: tb/tb_rv32i_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_rv32i_irq_controller
// Directed bench for rv32i_irq_controller (NUM_SRC=8). Each expected request
// (cause, id) is queued as the stimulus is issued; a separate monitor pops and
// compares on every rising edge of irq_req and checks the request stays
// stable while it is held. Directed checks cover pending bits, reset and
// handshake behaviour.
// -----------------------------------------------------------------------------
module tb_rv32i_irq_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_src;
    logic [7:0]  irq_enable;
    logic        irq_ack;
    logic        irq_complete;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic [4:0]  active_id;
    logic [7:0]  pending;

    typedef struct {
        logic [31:0] cause;
        logic [4:0]  id;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   total;
    int   bad;

    rv32i_irq_controller #(
        .NUM_SRC    (8),
        .CAUSE_BASE (32'h8000_000B)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .irq_enable   (irq_enable),
        .irq_ack      (irq_ack),
        .irq_complete (irq_complete),
        .irq_req      (irq_req),
        .irq_cause    (irq_cause),
        .active_id    (active_id),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Drive one clock edge with the given inputs, then drop the pulses
    task automatic cyc(input logic [7:0] src, input logic ack, input logic cmp);
        irq_src      = src;
        irq_ack      = ack;
        irq_complete = cmp;
        @(posedge clk);
        #1;
        irq_ack      = 1'b0;
        irq_complete = 1'b0;
    endtask

    task automatic expect_req(input logic [4:0] id);
        exp_t e;
        e.id    = id;
        e.cause = 32'h8000_000B + {27'd0, id};
        exp_q.push_back(e);
    endtask

    // Monitor: compare each new request against the scoreboard queue
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (irq_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", {27'd0, active_id}, 32'hFFFF_FFFF);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("req_cause", irq_cause, cur_exp.cause);
                        check("req_id", {27'd0, active_id}, {27'd0, cur_exp.id});
                    end
                end else if (irq_req) begin
                    check("held_cause", irq_cause, cur_exp.cause);
                end
                prev_req = irq_req;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        irq_src      = 8'h00;
        irq_enable   = 8'hFF;
        irq_ack      = 1'b0;
        irq_complete = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req", irq_req, 32'd0);
        check("rst_cause", irq_cause, 32'd0);
        check("rst_id", active_id, 32'd0);
        check("rst_pending", pending, 32'd0);

        // Single event on source 3
        expect_req(5'd3);
        cyc(8'h08, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_pending", pending, 32'h08);
        check("t1_noreq_yet", irq_req, 32'd0);
        cyc(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_req", irq_req, 32'd1);
        check("t1_cause", irq_cause, 32'h8000_000E);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_ack_req", irq_req, 32'd0);
        check("t1_ack_cause", irq_cause, 32'd0);
        check("t1_ack_pending", pending, 32'd0);
        check("t1_svc_id", active_id, 32'd3);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_cmp_id", active_id, 32'd0);
        check("t1_cmp_req", irq_req, 32'd0);

        // Priority and no preemption: 5 and 2 together, then 0 during REQ
        expect_req(5'd2);
        expect_req(5'd0);
        expect_req(5'd5);
        cyc(8'h24, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h01, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_nopreempt_cause", irq_cause, 32'h8000_000D);
        check("t2_nopreempt_id", active_id, 32'd2);
        check("t2_pending", pending, 32'h25);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_second_id", active_id, 32'd0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_third_cause", irq_cause, 32'h8000_0010);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("t2_pending_empty", pending, 32'd0);

        // Masking: disabled source 0 waits until its enable rises
        irq_enable = 8'hFE;
        expect_req(5'd0);
        cyc(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 1'b0, 1'b0);
            @(negedge clk);
            check("t3_masked_req", irq_req, 32'd0);
        end
        check("t3_masked_pending", pending, 32'h01);
        irq_enable = 8'hFF;
        cyc(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t3_unmask_req", irq_req, 32'd1);
        check("t3_unmask_cause", irq_cause, 32'h8000_000B);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);

        // Set wins over ack clear on source 4
        expect_req(5'd4);
        expect_req(5'd4);
        cyc(8'h10, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h10, 1'b1, 1'b0);
        @(negedge clk);
        check("t4_setwins_pending", pending, 32'h10);
        check("t4_ack_req", irq_req, 32'd0);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_rereq", irq_req, 32'd1);
        check("t4_rereq_id", active_id, 32'd4);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);

        // Stray pulses
        cyc(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("t5_idle_ack_req", irq_req, 32'd0);
        check("t5_idle_ack_id", active_id, 32'd0);
        expect_req(5'd7);
        cyc(8'h80, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_req_cmp_req", irq_req, 32'd1);
        check("t5_req_cmp_cause", irq_cause, 32'h8000_0012);
        cyc(8'h00, 1'b1, 1'b1);
        @(negedge clk);
        check("t5_both_req", irq_req, 32'd0);
        check("t5_both_id", active_id, 32'd7);
        cyc(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_idle_id", active_id, 32'd0);

        // Reset mid-SERVICE with pending 8'h30
        expect_req(5'd1);
        cyc(8'h02, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h30, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_pre_pending", pending, 32'h30);
        check("t6_pre_id", active_id, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_req", irq_req, 32'd0);
        check("t6_rst_cause", irq_cause, 32'd0);
        check("t6_rst_id", active_id, 32'd0);
        check("t6_rst_pending", pending, 32'd0);
        irq_src = 8'h01;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_req(5'd0);
        cyc(8'h01, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_post_pending", pending, 32'h01);
        check("t6_post_noreq", irq_req, 32'd0);
        cyc(8'h01, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_post_req", irq_req, 32'd1);
        check("t6_post_cause", irq_cause, 32'h8000_000B);
        cyc(8'h01, 1'b1, 1'b0);
        cyc(8'h01, 1'b0, 1'b1);
        @(negedge clk);
        check("t6_end_pending", pending, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_irq_controller.md
# rv32i_irq_controller

Machine-level external interrupt source for the RV32I core. It captures rising edges on up to 31 peripheral interrupt lines as pending bits and applies a per-source enable mask. It arbitrates by fixed priority and presents one registered interrupt request with its cause code to the core's exception handler. It holds off further requests until the core acknowledges the trap and signals completion of the handler (MRET).

## Interface
Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 2..31; source index 0 has highest priority.
- CAUSE_BASE, 32'h8000_000B, cause code for source 0; source i reports CAUSE_BASE + i.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- irq_src  input  NUM_SRC  interrupt lines, synchronous to clk; a rising edge is an event.
- irq_enable  input  NUM_SRC  per-source enable mask; masks arbitration only, not capture.
- irq_ack  input  1  one-cycle pulse from the core: trap taken for the presented request.
- irq_complete  input  1  one-cycle pulse from the core: handler finished (MRET).
- irq_req  output  1  registered interrupt request; drives the core's mei_exception.
- irq_cause  output  32  registered cause; drives mei_cause.
- active_id  output  5  index of the source being requested or serviced.
- pending  output  NUM_SRC  registered pending bits.

## Operation
- Edge capture: prev_src register; event_i = irq_src[i] & ~prev_src[i].
  - prev_src resets to 0, so a line already high at reset release produces an event on the first clock.
- Pending: bit i sets on event_i; it clears only when the core acknowledges source i.
  - Set wins over clear in the same cycle: a new edge on the acknowledged source re-pends it.
- Arbitration: the candidate is the lowest index with pending & irq_enable set; any_cand is the OR of all candidates.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: irq_req=0, irq_cause=0, active_id=0. If any_cand is set, latch the candidate index into active_id and go to REQ.
  - REQ: irq_req=1 and irq_cause=CAUSE_BASE+active_id, both held stable.
    - The request is never withdrawn or re-arbitrated. A higher-priority arrival, or the enable of active_id dropping, does not change it.
    - On irq_ack: clear pending[active_id] (subject to set-wins), drop irq_req, go to SERVICE.
  - SERVICE: irq_req=0, irq_cause=0, active_id holds. On irq_complete go to IDLE and clear active_id to 0.
- Pulse handling:
  - irq_ack outside REQ and irq_complete outside SERVICE are ignored.
  - If irq_ack and irq_complete arrive together in REQ, only irq_ack acts.
- Cause arithmetic: 32-bit add, active_id zero-extended; no overflow check.
- Reset (asserted at any time, including mid-REQ or mid-SERVICE):
  - state=IDLE; pending, prev_src, irq_req, irq_cause and active_id all 0.
  - An event in flight is lost.

## Timing
- Edge on irq_src sampled at clock k: the pending bit is visible after k; irq_req is high after k+1 (two-clock latency), provided the FSM is in IDLE and the source is enabled.
- irq_req, irq_cause and active_id change together on the same edge; all are register outputs with no combinational path from inputs.
- irq_ack sampled at clock m: irq_req is low and the pending bit is cleared after m.
- irq_complete sampled at clock c: IDLE after c; earliest next irq_req is after c+1.
- Throughput: at most one interrupt per ack/complete round trip. Events arriving during REQ or SERVICE accumulate in pending, one bit per source; repeated edges on an already-pending source merge.
- A source that is pending but disabled waits indefinitely; it is requested after its enable rises, with the usual one-clock IDLE arbitration latency.

## Test plan
- Single event: NUM_SRC=8, enable=8'hFF, pulse irq_src[3] high at clock 5 → pending=8'h08 after clock 5; irq_req=1, irq_cause=32'h8000_000E, active_id=3 after clock 6; irq_ack at clock 9 → irq_req=0, pending=0; irq_complete at clock 12 → IDLE, active_id=0.
- Priority and no preemption: edges on sources 5 and 2 in the same clock → request for 2. An edge on 0 during REQ leaves the cause at 32'h8000_000D. After complete, source 0 is requested, then source 5.
- Masking: enable=8'hFE with an edge on source 0 → pending[0]=1 and irq_req stays 0. Raise enable[0] → irq_req after the following clock with cause 32'h8000_000B.
- Set-wins: a new edge on the active source in the same clock as irq_ack → pending bit remains 1. After complete, the same source is requested again.
- Stray pulses: irq_ack in IDLE and irq_complete in REQ → no state change, request held.
- Reset mid-SERVICE with pending=8'h30: deassert rst_n asynchronously → all outputs 0 immediately. After release with irq_src held 8'h01 → event captured and irq_req rises two clocks later.
